// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle for alu_serial.
// master: requester (drives start and operands); slave: the ALU.
interface alu_serial_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, A, B, cntrl,
        input  busy, done, result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  start, A, B, cntrl,
        output busy, done, result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes a WIDTH-bit op DIGIT bits per clock, LSB digit
// first, carrying the inter-digit carry in a register. Flags N/Z/V/C are
// registered together with the result when the last digit completes.
// Optional macro ALU_SLT_EN: cntrl 111 becomes signed set-less-than.
module alu_serial #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    alu_serial_if.slave bus
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic             is_sub, is_add, start_sub;
    logic [DIGIT-1:0] a_dig, b_dig, bx_dig, res_dig;
    logic [DIGIT:0]   sum;
    logic [WIDTH-1:0] acc_full, fin_res;
    logic             cin_msb, v;

    // Digit datapath: one chunk of the operation on the low digit of the operand shifters
    always_comb begin
        is_add = (op_q == 3'b010);
        is_sub = (op_q == 3'b011);
`ifdef ALU_SLT_EN
        if (op_q == 3'b111) is_sub = 1'b1;
`endif
        a_dig  = a_q[DIGIT-1:0];
        b_dig  = b_q[DIGIT-1:0];
        bx_dig = is_sub ? ~b_dig : b_dig;
        sum    = {1'b0, a_dig} + {1'b0, bx_dig} + {{DIGIT{1'b0}}, carry_q};
        case (op_q)
            3'b000:  res_dig = b_dig;
            3'b010,
            3'b011:  res_dig = sum[DIGIT-1:0];
            3'b100:  res_dig = a_dig & b_dig;
            3'b101:  res_dig = a_dig | b_dig;
            3'b110:  res_dig = a_dig ^ b_dig;
`ifdef ALU_SLT_EN
            3'b111:  res_dig = sum[DIGIT-1:0];
`endif
            default: res_dig = '0;
        endcase
        // New digit enters at the top; after NCHUNK shifts the LSB digit sits at bit 0
        acc_full = (acc_q >> DIGIT) | (WIDTH'(res_dig) << (WIDTH - DIGIT));
        // Only meaningful on the last chunk, where bit DIGIT-1 is the word MSB
        cin_msb  = sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ bx_dig[DIGIT-1];
        v        = cin_msb ^ sum[DIGIT];
        fin_res  = acc_full;
`ifdef ALU_SLT_EN
        if (op_q == 3'b111) begin
            fin_res    = '0;
            fin_res[0] = acc_full[WIDTH-1] ^ v;
        end
`endif
    end

    // Control FSM: operand capture on accepted start, per-digit stepping, final latch
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        result_d  = result_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        start_sub = (bus.cntrl == 3'b011);
`ifdef ALU_SLT_EN
        if (bus.cntrl == 3'b111) start_sub = 1'b1;
`endif
        case (state_q)
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_full;
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    result_d = fin_res;
                    neg_d    = fin_res[WIDTH-1];
                    zero_d   = (fin_res == '0);
                    ovf_d    = (is_add || op_q == 3'b011) ? v : 1'b0;
                    cout_d   = (is_add || op_q == 3'b011) ? sum[DIGIT] : 1'b0;
                    state_d  = DONE;
                end
            end
            default: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.cntrl;
                    cnt_d   = '0;
                    carry_d = start_sub;
                    acc_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: two instances (DIGIT=8 and DIGIT=WIDTH) share stimulus;
// a behavioural model predicts outputs every cycle, plus literal expectations.
module tb_alu_serial;
    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] res;
        logic n, z, v, c;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_serial_if #(.WIDTH(W)) if0 ();
    alu_serial_if #(.WIDTH(W)) if1 ();

    assign if1.start = if0.start;
    assign if1.A     = if0.A;
    assign if1.B     = if0.B;
    assign if1.cntrl = if0.cntrl;

    alu_serial #(.WIDTH(W), .DIGIT(8)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    alu_serial #(.WIDTH(W), .DIGIT(W)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: the whole word at once with plain arithmetic
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        exp_t e;
        logic [W:0] s;
        e = '0;
        case (c)
            3'b000: e.res = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = a ^ b;
`ifdef ALU_SLT_EN
            3'b111: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
`endif
            default: e.res = '0;
        endcase
        e.n = e.res[W-1];
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic exp_t out0();
        return {if0.result, if0.negative, if0.zero, if0.overflow, if0.carry_out};
    endfunction
    function automatic exp_t out1();
        return {if1.result, if1.negative, if1.zero, if1.overflow, if1.carry_out};
    endfunction

    // Timing model: cycles remaining per instance, pending and visible outputs
    int   rem [2];
    exp_t pend[2];
    exp_t cur [2];
    logic dexp[2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                rem[i]  <= 0;
                cur[i]  <= '0;
                pend[i] <= '0;
                dexp[i] <= 1'b0;
            end else begin
                dexp[i] <= 1'b0;
                if (rem[i] == 0) begin
                    if (if0.start) begin
                        pend[i] <= model(if0.A, if0.B, if0.cntrl);
                        rem[i]  <= (i == 0) ? 8 : 1;
                    end
                end else begin
                    if (rem[i] == 1) begin
                        cur[i]  <= pend[i];
                        dexp[i] <= 1'b1;
                    end
                    rem[i] <= rem[i] - 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("m0_busy", if0.busy, rem[0] != 0);
        chk("m0_done", if0.done, dexp[0]);
        chk("m0_out",  out0(),   cur[0]);
        chk("m1_busy", if1.busy, rem[1] != 0);
        chk("m1_done", if1.done, dexp[1]);
        chk("m1_out",  out1(),   cur[1]);
    end

    // Launch one op (call just after a rising edge); returns latencies and outputs at done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                          input bit pulses, output int lat0, output int lat1,
                          output exp_t got0, output exp_t got1);
        lat0 = 0; lat1 = 0; got0 = '0; got1 = '0;
        if0.A = a; if0.B = b; if0.cntrl = c; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        if0.A = ~a; if0.B = ~b; if0.cntrl = 3'b101;
        chk("accept_busy", if0.busy, 1'b1);
        chk("accept_nodone", if0.done, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if0.start = 1'b0;
            if (pulses && (n == 2 || n == 5)) begin
                if0.start = 1'b1;
                if0.A = 64'h1234; if0.B = 64'h00FF; if0.cntrl = 3'b010;
            end
            if (if1.done && lat1 == 0) begin lat1 = n; got1 = out1(); end
            if (if0.done) begin lat0 = n; got0 = out0(); break; end
        end
        if0.start = 1'b0;
        if (lat0 == 0) chk("timeout", 1'b1, 1'b0);
    endtask

    int   l0, l1;
    exp_t g0, g1;

    initial begin
        if0.start = 1'b0; if0.A = '0; if0.B = '0; if0.cntrl = '0;
        #2;
        chk("rst_out",  out0(), 68'd0);
        chk("rst_busy", {if0.busy, if0.done}, 2'b00);
        // Pin the reference model with hand-computed values
        chk("pin_add", model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010), {64'h8000_0000_0000_0000, 4'b1010});
        chk("pin_sub0", model(64'd5, 64'd5, 3'b011), {64'd0, 4'b0101});
        chk("pin_subn", model(64'd0, 64'd1, 3'b011), {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Signed overflow on add
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 0, l0, l1, g0, g1);
        chk("add_lat", l0, 8);
        chk("add_res", g0, {64'h8000_0000_0000_0000, 4'b1010});
        chk("add_lat1", l1, 1);
        @(posedge clk); #1;

        // Subtraction: equal operands, then borrow
        run_op(64'd5, 64'd5, 3'b011, 0, l0, l1, g0, g1);
        chk("sub0_res", g0, {64'd0, 4'b0101});
        run_op(64'd0, 64'd1, 3'b011, 0, l0, l1, g0, g1);
        chk("subn_res", g0, {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000});
        @(posedge clk); #1;

        // Back-to-back: second start issued in the DONE cycle, stray pulses during RUN
        run_op(64'hF0F0, 64'hFF00, 3'b100, 0, l0, l1, g0, g1);
        chk("and_res", g0.res, 64'hF000);
        run_op(64'hF0F0, 64'hFF00, 3'b110, 1, l0, l1, g0, g1);
        chk("xor_lat", l0, 8);
        chk("xor_res", g0.res, 64'h0FF0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Single-chunk instance: pass-through and unused code
        run_op(64'd3, 64'd9, 3'b000, 0, l0, l1, g0, g1);
        chk("pass_lat1", l1, 1);
        chk("pass_res1", g1, {64'd9, 4'b0000});
        run_op(64'd3, 64'd9, 3'b001, 0, l0, l1, g0, g1);
        chk("nop_res1", g1, {64'd0, 4'b0100});
        chk("nop_res0", g0, {64'd0, 4'b0100});

        // Set-less-than (or unused code 111)
        run_op(-64'sd2, 64'd1, 3'b111, 0, l0, l1, g0, g1);
`ifdef ALU_SLT_EN
        chk("slt_a", g0, {64'd1, 4'b0000});
`else
        chk("slt_a", g0, {64'd0, 4'b0100});
`endif
        run_op(64'd1, -64'sd2, 3'b111, 0, l0, l1, g0, g1);
        chk("slt_b", g0, {64'd0, 4'b0100});
        @(posedge clk); #1;

        // Reset asserted mid-RUN: immediate clear, no done, then normal operation
        if0.A = 64'hFFFF; if0.B = 64'h1; if0.cntrl = 3'b010; if0.start = 1'b1;
        @(posedge clk); #1 if0.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {out0(), out1()}, 136'd0);
        chk("mid_rst_hs", {if0.busy, if0.done}, 2'b00);
        @(posedge clk); #3 reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (n == 0 || n == 9) chk("no_done", if0.done, 1'b0);
        end
        run_op(64'hFFFF, 64'h1, 3'b010, 0, l0, l1, g0, g1);
        chk("post_rst_lat", l0, 8);
        chk("post_rst_res", g0, {64'h10000, 4'b0000});
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised, digit-serial successor to the 1-bit ALU slice.
- Processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first, using the team's 3-bit cntrl encoding.
- Carries the inter-digit carry in a register.
- Produces N/Z/V/C flags for the CPU datapath and hands off with a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand/result width in bits. Must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle. 1 <= DIGIT <= WIDTH. NCHUNK = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when not busy
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- cntrl  input  3  operation, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags valid from this cycle on
- result  output  WIDTH  operation result
- negative  output  1  result[WIDTH-1]
- zero  output  1  result == 0
- overflow  output  1  signed overflow, arithmetic ops only
- carry_out  output  1  carry out of the MSB, arithmetic ops only

Behaviour:
- Operation codes:
  - 000 result=B
  - 010 A+B
  - 011 A-B, computed as A + ~B + 1
  - 100 A&B
  - 101 A|B
  - 110 A^B
  - 001 and 111: result=0 (111 changes under the optional feature).
- States: IDLE, RUN, DONE.
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, negative=0, zero=0, overflow=0, carry_out=0; internal operand registers, digit counter and carry cleared.
- IDLE or DONE, start=1 at an edge:
  - latch A, B, cntrl;
  - digit counter=0;
  - carry register = 1 if cntrl==011, else 0;
  - go to RUN.
- IDLE or DONE, start=0: DONE goes to IDLE; IDLE holds.
- RUN, each edge, chunk k = counter:
  - compute DIGIT bits of the op on A[k], B[k] (B inverted for 011) plus the carry register;
  - write the result digit into a shift/accumulate register;
  - update the carry register;
  - increment the counter.
- RUN, edge processing chunk NCHUNK-1:
  - register the final result and flags;
  - go to DONE.
- Latency: done is high for exactly one cycle, starting NCHUNK edges after the accepting start edge.
- busy=1 exactly in RUN. start while busy is ignored; no queueing.
- Back-to-back: start=1 during DONE is accepted. done drops the next cycle and a new RUN begins.
- result and flags update only at the RUN->DONE edge. They hold through IDLE and through the following RUN until the next DONE.
- Flags:
  - zero and negative are valid for every code.
  - overflow = carry into MSB XOR carry out of MSB, for 010/011 only.
  - carry_out = final carry, for 010/011 only.
  - For all non-arithmetic codes, overflow=0 and carry_out=0.
- Subtraction carry_out follows the A + ~B + 1 convention: 1 means no borrow.
- Reset asserted mid-RUN aborts the operation with no done pulse; outputs return to reset values.
- Operand inputs may change freely after the accepting edge without affecting the operation in flight.
- DIGIT==WIDTH is legal: NCHUNK=1, and done follows start by one edge.

Optional Feature:
- Macro: ALU_SLT_EN.
- Defined: cntrl 111 = signed set-less-than.
  - Run as a subtraction: carry register init=1, B inverted.
  - Final result = {WIDTH-1 zeros, (msb_sum XOR v)}, where v is the subtraction overflow.
  - zero and negative reflect that final result; overflow=0, carry_out=0.
- Not defined: 111 behaves as an unused code (result=0, zero=1, other flags 0), and no SLT logic is synthesised.

Test Plan:
- WIDTH=64, DIGIT=8: reset_n low mid-RUN -> all outputs 0 immediately, no done, state IDLE; a subsequent start works normally.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010 -> done exactly 8 cycles after the start edge, busy high 8 cycles; result=0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
- A=5, B=5, cntrl=011 -> result=0, zero=1, carry_out=1, overflow=0. Then A=0, B=1, cntrl=011 -> result=all ones, negative=1, carry_out=0.
- Back-to-back:
  - cntrl=100 on A=0xF0F0, B=0xFF00 -> result 0xF000;
  - start re-asserted in the DONE cycle with cntrl=110, same operands -> second done 8 cycles later, result 0x0FF0;
  - start pulses asserted during RUN are ignored.
- DIGIT=64, NCHUNK=1, A=3, B=9, cntrl=000 -> done one edge after start, result=9. Then cntrl=001 -> result=0, zero=1.
- ALU_SLT_EN defined, A=-2, B=1, cntrl=111 -> result=1. Then A=1, B=-2 -> result=0, zero=1.
- ALU_SLT_EN undefined, same stimulus -> result=0 both times.
